fp_mul_pipe: RTL

FP_MUL_PIPE -- requirements
Module: fp_mul_pipe

---
 rtl/fp_pkg.sv | 53 +++++
 rtl/fp_round.sv | 79 +++++++
 rtl/fp_mul_pipe.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// Shared types and helpers for the pipelined floating-point multiplier.
package fp_pkg;

    // Operand / result class after unpacking (subnormals are folded into ZERO)
    typedef enum logic [2:0] {
        ZERO,
        NORM,
        INF,
        QNAN,
        SNAN
    } fp_class_t;

    // Exception flags travelling with each result
    typedef struct packed {
        logic invalid;
        logic overflow;
        logic underflow;
        logic inexact;
    } fp_flags_t;

    // Exponent bias for a given exponent field width
    function automatic int unsigned fp_bias(input int unsigned exp_w);
        return (32'd1 << (exp_w - 32'd1)) - 32'd1;
    endfunction

    // Canonical quiet NaN, right-aligned in a 64-bit word; callers truncate to W
    function automatic logic [63:0] fp_qnan(input int unsigned exp_w, input int unsigned man_w);
        logic [63:0] r;
        r = (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 32'd1));
        return r;
    endfunction

    // Classify from exponent/fraction summary bits
    function automatic fp_class_t fp_classify(input logic exp_ones, input logic exp_zero,
                                              input logic frac_zero, input logic frac_msb);
        fp_class_t c;
        if (exp_zero) begin
            c = ZERO;
        end else if (exp_ones) begin
            if (frac_zero) begin
                c = INF;
            end else if (frac_msb) begin
                c = QNAN;
            end else begin
                c = SNAN;
            end
        end else begin
            c = NORM;
        end
        return c;
    endfunction

endpackage

// File: rtl/fp_round.sv
// Third stage: normalise, round, pack and generate flags (combinational).
// FPMUL_RNE_EN selects round-to-nearest-even; otherwise truncation with
// overflow saturating to the largest finite magnitude.
module fp_round
    import fp_pkg::*;
#(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  fp_class_t                  cls,
    input  logic                       invalid,
    input  logic                       sign,
    input  logic signed [EXP_W+1:0]    exp_sum,
    input  logic [2*MAN_W+1:0]         prod,
    output logic [EXP_W+MAN_W:0]       y_c,
    output fp_flags_t                  flags_c
);

    localparam int unsigned W  = 1 + EXP_W + MAN_W;
    localparam int unsigned XW = EXP_W + 2;
    localparam int unsigned PW = 2 * MAN_W + 2;
    localparam logic signed [XW-1:0] EXP_MAX = $signed(XW'((32'd1 << EXP_W) - 32'd1));

    logic [PW-2:0]          norm;
    logic [MAN_W-1:0]       frac;
    logic                   guard;
    logic                   sticky;
    logic                   lost;
    logic                   inc;
    logic [MAN_W:0]         frac_r;
    logic signed [XW-1:0]   exp_r;

    // Left-justify, round and select the packed result for the class
    always_comb begin
        y_c     = '0;
        flags_c = '0;

        norm   = prod[PW-1] ? prod[PW-2:0] : {prod[PW-3:0], 1'b0};
        frac   = norm[PW-2 -: MAN_W];
        guard  = norm[MAN_W];
        sticky = |norm[MAN_W-1:0];
        lost   = guard | sticky;
`ifdef FPMUL_RNE_EN
        inc    = guard & (sticky | frac[0]);
`else
        inc    = 1'b0;
`endif
        frac_r = {1'b0, frac} + (MAN_W+1)'(inc);
        exp_r  = exp_sum + $signed(XW'(prod[PW-1])) + $signed(XW'(frac_r[MAN_W]));

        case (cls)
            ZERO: y_c = {sign, {(W-1){1'b0}}};
            INF:  y_c = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            QNAN, SNAN: begin
                y_c             = W'(fp_qnan(EXP_W, MAN_W));
                flags_c.invalid = invalid;
            end
            default: begin
                if (!exp_r[XW-1] && (exp_r >= EXP_MAX)) begin
`ifdef FPMUL_RNE_EN
                    y_c = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
`else
                    y_c = {sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
`endif
                    flags_c.overflow = 1'b1;
                    flags_c.inexact  = 1'b1;
                end else if (exp_r[XW-1] || (exp_r == '0)) begin
                    y_c               = {sign, {(W-1){1'b0}}};
                    flags_c.underflow = 1'b1;
                    flags_c.inexact   = 1'b1;
                end else begin
                    y_c             = {sign, exp_r[EXP_W-1:0], frac_r[MAN_W-1:0]};
                    flags_c.inexact = lost;
                end
            end
        endcase
    end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined floating-point multiplier with global stall.
// Define FPMUL_RNE_EN for round-to-nearest-even; default build truncates.
module fp_mul_pipe
    import fp_pkg::*;
#(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   y,
    output logic [3:0]             flags
);

    localparam int unsigned W  = 1 + EXP_W + MAN_W;
    localparam int unsigned XW = EXP_W + 2;
    localparam int unsigned PW = 2 * MAN_W + 2;
    localparam int unsigned MW = MAN_W + 1;

    logic                   stall;
    logic                   adv;
    fp_class_t              cls_a, cls_b, res_cls;
    logic                   res_inv;

    logic                   v1, s1_sign, s1_inv;
    fp_class_t              s1_cls;
    logic [EXP_W-1:0]       s1_ea, s1_eb;
    logic [MW-1:0]          s1_ma, s1_mb;

    logic                   v2, s2_sign, s2_inv;
    fp_class_t              s2_cls;
    logic signed [XW-1:0]   s2_exp;
    logic [PW-1:0]          s2_prod;

    logic [W-1:0]           r_y;
    fp_flags_t              r_flags;

    // A held result blocks every stage
    assign stall    = out_valid & ~out_ready;
    assign adv      = ~stall;
    assign in_ready = adv;

    // Classify operands and resolve special-case result class
    always_comb begin
        cls_a   = fp_classify(&a[W-2 -: EXP_W], ~|a[W-2 -: EXP_W], ~|a[MAN_W-1:0], a[MAN_W-1]);
        cls_b   = fp_classify(&b[W-2 -: EXP_W], ~|b[W-2 -: EXP_W], ~|b[MAN_W-1:0], b[MAN_W-1]);
        res_cls = NORM;
        res_inv = 1'b0;
        if ((cls_a == QNAN) || (cls_a == SNAN) || (cls_b == QNAN) || (cls_b == SNAN)) begin
            res_cls = QNAN;
            res_inv = (cls_a == SNAN) || (cls_b == SNAN);
        end else if (((cls_a == INF) && (cls_b == ZERO)) || ((cls_a == ZERO) && (cls_b == INF))) begin
            res_cls = QNAN;
            res_inv = 1'b1;
        end else if ((cls_a == INF) || (cls_b == INF)) begin
            res_cls = INF;
        end else if ((cls_a == ZERO) || (cls_b == ZERO)) begin
            res_cls = ZERO;
        end
    end

    // S1: capture unpacked operands on input transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1      <= 1'b0;
            s1_sign <= 1'b0;
            s1_inv  <= 1'b0;
            s1_cls  <= ZERO;
            s1_ea   <= '0;
            s1_eb   <= '0;
            s1_ma   <= '0;
            s1_mb   <= '0;
        end else if (adv) begin
            v1 <= in_valid;
            if (in_valid) begin
                s1_sign <= a[W-1] ^ b[W-1];
                s1_inv  <= res_inv;
                s1_cls  <= res_cls;
                s1_ea   <= a[W-2 -: EXP_W];
                s1_eb   <= b[W-2 -: EXP_W];
                s1_ma   <= {1'b1, a[MAN_W-1:0]};
                s1_mb   <= {1'b1, b[MAN_W-1:0]};
            end
        end
    end

    // S2: mantissa product and biased exponent sum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2      <= 1'b0;
            s2_sign <= 1'b0;
            s2_inv  <= 1'b0;
            s2_cls  <= ZERO;
            s2_exp  <= '0;
            s2_prod <= '0;
        end else if (adv) begin
            v2 <= v1;
            if (v1) begin
                s2_sign <= s1_sign;
                s2_inv  <= s1_inv;
                s2_cls  <= s1_cls;
                s2_exp  <= $signed(XW'(s1_ea)) + $signed(XW'(s1_eb)) - $signed(XW'(fp_bias(EXP_W)));
                s2_prod <= PW'(s1_ma) * PW'(s1_mb);
            end
        end
    end

    fp_round #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_round (
        .cls     (s2_cls),
        .invalid (s2_inv),
        .sign    (s2_sign),
        .exp_sum (s2_exp),
        .prod    (s2_prod),
        .y_c     (r_y),
        .flags_c (r_flags)
    );

    // S3: register the packed result; bubbles clear the data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            y         <= '0;
            flags     <= '0;
        end else if (adv) begin
            out_valid <= v2;
            y         <= v2 ? r_y : '0;
            flags     <= v2 ? r_flags : '0;
        end
    end

endmodule
